// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage. Owns the PC, fetches one instruction word per
// instruction over a req/ack handshake with instruction memory, presents it
// downstream with a valid/taken handshake, then waits for the EX stage to
// supply the next PC. Only one instruction is in flight at a time.
//
// Configuration macro: IF_FETCH_ALIGN_TRAP_EN
//   defined   : a misaligned next-PC load redirects to FAULT_PC and sets the
//               sticky fetchFault flag.
//   undefined : the low two bits of a next-PC load are cleared and
//               fetchFault stays 0.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   toPC         in   next PC from EX stage
//   nextPCValid  in   one-cycle strobe qualifying toPC
//   imemReq      out  instruction memory read request
//   imemAddr     out  read address (current PC)
//   imemAck      in   read complete, imemData valid this cycle
//   imemData     in   instruction word from memory
//   instr        out  fetched instruction
//   incrPC       out  PC+4 of the fetched instruction
//   instrValid   out  instr/incrPC valid for downstream
//   instrTaken   in   downstream accepts instr (qualified by instrValid)
//   fetchCount   out  number of instructions handed downstream (wraps)
//   fetchFault   out  sticky misaligned-target flag
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] FAULT_PC = 32'h0000_0080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] toPC,
  input  logic        nextPCValid,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [31:0] incrPC,
  output logic        instrValid,
  input  logic        instrTaken,
  output logic [31:0] fetchCount,
  output logic        fetchFault
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_VALID  = 2'd2,
    S_WAITPC = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] pendPc_r;
  logic        pendV_r;
  logic [32:0] directLoad_s;
  logic [32:0] pendLoad_s;

  // Resolve a next-PC target into {fault, pcToLoad}.
  function automatic logic [32:0] loadTarget(input logic [31:0] target);
`ifdef IF_FETCH_ALIGN_TRAP_EN
    if (target[1:0] != 2'b00) begin
      loadTarget = {1'b1, FAULT_PC};
    end else begin
      loadTarget = {1'b0, target};
    end
`else
    loadTarget = {1'b0, target & 32'hFFFF_FFFC};
`endif
  endfunction

  // Candidate PC loads from the live strobe and from the pending register.
  always_comb begin
    directLoad_s = loadTarget(toPC);
    pendLoad_s   = loadTarget(pendPc_r);
  end

  // Fetch state machine; every output is a register written here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= S_IDLE;
      pc_r       <= RESET_PC;
      pendPc_r   <= 32'h0000_0000;
      pendV_r    <= 1'b0;
      imemReq    <= 1'b0;
      imemAddr   <= RESET_PC;
      instr      <= 32'h0000_0000;
      incrPC     <= 32'h0000_0000;
      instrValid <= 1'b0;
      fetchCount <= 32'h0000_0000;
      fetchFault <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          imemReq <= 1'b1;
          state_r <= S_REQ;
        end
        S_REQ: begin
          // A next-PC strobe during the fetch is parked until hand-off.
          if (nextPCValid) begin
            pendPc_r <= toPC;
            pendV_r  <= 1'b1;
          end
          if (imemAck) begin
            instr      <= imemData;
            incrPC     <= pc_r + 32'd4;
            imemReq    <= 1'b0;
            instrValid <= 1'b1;
            state_r    <= S_VALID;
          end
        end
        S_VALID: begin
          if (instrTaken) begin
            fetchCount <= fetchCount + 32'd1;
            instrValid <= 1'b0;
            if (nextPCValid) begin
              // Live strobe supersedes anything parked earlier.
              pc_r       <= directLoad_s[31:0];
              imemAddr   <= directLoad_s[31:0];
              fetchFault <= fetchFault | directLoad_s[32];
              pendV_r    <= 1'b0;
              imemReq    <= 1'b1;
              state_r    <= S_REQ;
            end else if (pendV_r) begin
              pc_r       <= pendLoad_s[31:0];
              imemAddr   <= pendLoad_s[31:0];
              fetchFault <= fetchFault | pendLoad_s[32];
              pendV_r    <= 1'b0;
              imemReq    <= 1'b1;
              state_r    <= S_REQ;
            end else begin
              state_r <= S_WAITPC;
            end
          end else if (nextPCValid) begin
            pendPc_r <= toPC;
            pendV_r  <= 1'b1;
          end
        end
        S_WAITPC: begin
          if (nextPCValid) begin
            pc_r       <= directLoad_s[31:0];
            imemAddr   <= directLoad_s[31:0];
            fetchFault <= fetchFault | directLoad_s[32];
            imemReq    <= 1'b1;
            state_r    <= S_REQ;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          imemReq    <= 1'b0;
          instrValid <= 1'b0;
          pendV_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] FAULT_PC = 32'h0000_0080;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] toPC = 32'h0;
  logic        nextPCValid = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] instr;
  logic [31:0] incrPC;
  logic        instrValid;
  logic        instrTaken = 1'b0;
  logic [31:0] fetchCount;
  logic        fetchFault;

  int checks = 0;
  int failures = 0;

  // Reference state of the fetch stream
  logic [31:0] expAddr;
  logic [31:0] expCount;
  logic        expFault;

  if_fetch_unit #(.RESET_PC(RESET_PC), .FAULT_PC(FAULT_PC)) dut (
    .clock(clock), .reset(reset), .toPC(toPC), .nextPCValid(nextPCValid),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemData(imemData),
    .instr(instr), .incrPC(incrPC), .instrValid(instrValid), .instrTaken(instrTaken),
    .fetchCount(fetchCount), .fetchFault(fetchFault)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Memory contents as a pure function of address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a * 32'd2654435761 + 32'd12345;
  endfunction

  // Address the next fetch should use for a given EX target
  function automatic logic [31:0] modelTarget(input logic [31:0] t);
`ifdef IF_FETCH_ALIGN_TRAP_EN
    return (t % 32'd4 != 32'd0) ? FAULT_PC : t;
`else
    return t - (t % 32'd4);
`endif
  endfunction

  function automatic logic modelFault(input logic [31:0] t);
`ifdef IF_FETCH_ALIGN_TRAP_EN
    return (t % 32'd4 != 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic test_reset;
    #12;
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL reset_req got %h want 0", imemReq); end
    checks++; if (imemAddr !== RESET_PC) begin failures++; $display("FAIL reset_addr got %h want %h", imemAddr, RESET_PC); end
    checks++; if ({instr, incrPC} !== 64'h0) begin failures++; $display("FAIL reset_instr got %h/%h want 0/0", instr, incrPC); end
    checks++; if ({instrValid, fetchCount, fetchFault} !== 34'h0) begin failures++; $display("FAIL reset_misc got v=%h c=%h f=%h want 0", instrValid, fetchCount, fetchFault); end
  endtask

  task automatic test_first_fetch;
    imemAck = 1'b1;
    imemData = 32'h2008_0005;
    @(posedge clock);
    #1 reset = 1'b0;
    step;  // idle -> req, ack ignored
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h0 || instrValid !== 1'b0) begin failures++; $display("FAIL first_req got req=%h addr=%h v=%h want 1/0/0", imemReq, imemAddr, instrValid); end
    step;
    checks++; if (instrValid !== 1'b1) begin failures++; $display("FAIL first_valid got %h want 1", instrValid); end
    checks++; if (instr !== 32'h2008_0005 || incrPC !== 32'h4) begin failures++; $display("FAIL first_data got %h/%h want 20080005/4", instr, incrPC); end
    imemAck = 1'b0;
  endtask

  task automatic test_taken_with_pc;
    instrTaken = 1'b1; nextPCValid = 1'b1; toPC = 32'h40;
    step;
    instrTaken = 1'b0; nextPCValid = 1'b0;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin failures++; $display("FAIL direct_pc got req=%h addr=%h want 1/40", imemReq, imemAddr); end
    checks++; if (fetchCount !== 32'd1 || instrValid !== 1'b0) begin failures++; $display("FAIL direct_count got c=%h v=%h want 1/0", fetchCount, instrValid); end
  endtask

  task automatic test_ack_delay;
    imemData = 32'hDEAD_0001;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h40 || instrValid !== 1'b0) begin failures++; $display("FAIL delay_hold%0d got req=%h addr=%h v=%h want 1/40/0", i, imemReq, imemAddr, instrValid); end
    end
    imemAck = 1'b1; imemData = 32'h1234_5678;
    step;
    checks++; if (instrValid !== 1'b1 || instr !== 32'h1234_5678 || incrPC !== 32'h44) begin failures++; $display("FAIL delay_capture got v=%h i=%h p=%h want 1/12345678/44", instrValid, instr, incrPC); end
    imemData = 32'hFFFF_0000;  // stray ack while valid must be ignored
    step;
    imemAck = 1'b0;
    checks++; if (instrValid !== 1'b1 || instr !== 32'h1234_5678 || imemReq !== 1'b0) begin failures++; $display("FAIL delay_single got v=%h i=%h req=%h want 1/12345678/0", instrValid, instr, imemReq); end
  endtask

  task automatic test_latest_wins;
    instrTaken = 1'b1;
    step;
    instrTaken = 1'b0;
    checks++; if (imemReq !== 1'b0 || instrValid !== 1'b0 || fetchCount !== 32'd2) begin failures++; $display("FAIL waitpc got req=%h v=%h c=%h want 0/0/2", imemReq, instrValid, fetchCount); end
    step;
    checks++; if (imemReq !== 1'b0) begin failures++; $display("FAIL waitpc_hold got %h want 0", imemReq); end
    nextPCValid = 1'b1; toPC = 32'h300;
    step;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h300) begin failures++; $display("FAIL waitpc_load got req=%h addr=%h want 1/300", imemReq, imemAddr); end
    toPC = 32'h100; step;
    toPC = 32'h200; step;
    nextPCValid = 1'b0;
    imemAck = 1'b1; imemData = memWord(32'h300);
    step;
    imemAck = 1'b0;
    checks++; if (instr !== memWord(32'h300) || incrPC !== 32'h304) begin failures++; $display("FAIL pend_fetch got %h/%h want %h/304", instr, incrPC, memWord(32'h300)); end
    instrTaken = 1'b1;
    step;
    instrTaken = 1'b0;
    checks++; if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin failures++; $display("FAIL latest_wins got req=%h addr=%h want 1/200", imemReq, imemAddr); end
  endtask

  task automatic test_misaligned;
    logic [31:0] want;
    logic wantF;
    imemAck = 1'b1; imemData = memWord(32'h200);
    step;
    imemAck = 1'b0;
    instrTaken = 1'b1; nextPCValid = 1'b1; toPC = 32'h42;
    step;
    instrTaken = 1'b0; nextPCValid = 1'b0;
`ifdef IF_FETCH_ALIGN_TRAP_EN
    want = FAULT_PC; wantF = 1'b1;
`else
    want = 32'h40; wantF = 1'b0;
`endif
    checks++; if (imemAddr !== want || fetchFault !== wantF) begin failures++; $display("FAIL misaligned got addr=%h f=%h want %h/%h", imemAddr, fetchFault, want, wantF); end
    expAddr = want;
  endtask

  task automatic test_pc_wrap;
    imemAck = 1'b1; imemData = memWord(expAddr);
    step;
    imemAck = 1'b0;
    instrTaken = 1'b1; nextPCValid = 1'b1; toPC = 32'hFFFF_FFFC;
    step;
    instrTaken = 1'b0; nextPCValid = 1'b0;
    checks++; if (imemAddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got %h want fffffffc", imemAddr); end
    imemAck = 1'b1; imemData = memWord(32'hFFFF_FFFC);
    step;
    imemAck = 1'b0;
    checks++; if (incrPC !== 32'h0 || instr !== memWord(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_incr got %h/%h want 0/%h", incrPC, instr, memWord(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_mid;
    instrTaken = 1'b1; nextPCValid = 1'b1; toPC = 32'h10;
    step;
    instrTaken = 1'b0; nextPCValid = 1'b0;
    checks++; if (imemReq !== 1'b1 || fetchCount !== 32'd6) begin failures++; $display("FAIL pre_reset got req=%h c=%h want 1/6", imemReq, fetchCount); end
    #2 reset = 1'b1;
    #1;
    checks++; if (imemReq !== 1'b0 || imemAddr !== RESET_PC) begin failures++; $display("FAIL async_reset got req=%h addr=%h want 0/%h", imemReq, imemAddr, RESET_PC); end
    checks++; if ({instr, incrPC, instrValid, fetchCount, fetchFault} !== 98'h0) begin failures++; $display("FAIL async_reset_out got i=%h p=%h v=%h c=%h f=%h want 0", instr, incrPC, instrValid, fetchCount, fetchFault); end
    @(posedge clock);
    #1 reset = 1'b0;
    imemAck = 1'b1; imemData = 32'hBAD0_BAD0;  // late ack from the aborted read
    step;
    imemAck = 1'b0;
    checks++; if (imemReq !== 1'b1 || imemAddr !== RESET_PC || instrValid !== 1'b0) begin failures++; $display("FAIL restart got req=%h addr=%h v=%h want 1/%h/0", imemReq, imemAddr, instrValid, RESET_PC); end
    expAddr = RESET_PC; expCount = 32'd0; expFault = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0] latest;
    logic haveT;
    logic [31:0] t;
    int d;
    for (int n = 0; n < 40; n++) begin
      haveT = 1'b0;
      checks++; if (imemReq !== 1'b1 || imemAddr !== expAddr || instrValid !== 1'b0) begin failures++; $display("FAIL rnd_req%0d got req=%h addr=%h v=%h want 1/%h/0", n, imemReq, imemAddr, instrValid, expAddr); end
      checks++; if (fetchFault !== expFault) begin failures++; $display("FAIL rnd_fault%0d got %h want %h", n, fetchFault, expFault); end
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        imemAck = (i == d);
        imemData = (i == d) ? memWord(expAddr) : $urandom;
        nextPCValid = ($urandom_range(0, 3) == 0);
        if (nextPCValid) begin
          t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
          toPC = t; latest = t; haveT = 1'b1;
        end
        step;
        if (i < d) begin
          checks++; if (imemReq !== 1'b1 || imemAddr !== expAddr || instrValid !== 1'b0) begin failures++; $display("FAIL rnd_hold%0d got req=%h addr=%h v=%h want 1/%h/0", n, imemReq, imemAddr, instrValid, expAddr); end
        end
      end
      imemAck = 1'b0; nextPCValid = 1'b0;
      checks++; if (instrValid !== 1'b1 || instr !== memWord(expAddr) || incrPC !== expAddr + 32'd4 || imemReq !== 1'b0) begin failures++; $display("FAIL rnd_data%0d got v=%h i=%h p=%h req=%h want 1/%h/%h/0", n, instrValid, instr, incrPC, imemReq, memWord(expAddr), expAddr + 32'd4); end
      d = $urandom_range(0, 2);
      for (int i = 0; i <= d; i++) begin
        instrTaken = (i == d);
        imemAck = ($urandom_range(0, 1) == 1);
        nextPCValid = ($urandom_range(0, 2) == 0);
        if (nextPCValid) begin
          t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
          toPC = t; latest = t; haveT = 1'b1;
        end
        step;
        if (i < d) begin
          checks++; if (instrValid !== 1'b1 || instr !== memWord(expAddr) || fetchCount !== expCount) begin failures++; $display("FAIL rnd_stall%0d got v=%h i=%h c=%h want 1/%h/%h", n, instrValid, instr, fetchCount, memWord(expAddr), expCount); end
        end
      end
      instrTaken = 1'b0; nextPCValid = 1'b0; imemAck = 1'b0;
      expCount = expCount + 32'd1;
      checks++; if (fetchCount !== expCount || instrValid !== 1'b0) begin failures++; $display("FAIL rnd_count%0d got c=%h v=%h want %h/0", n, fetchCount, instrValid, expCount); end
      if (!haveT) begin
        d = $urandom_range(0, 2);
        for (int i = 0; i <= d; i++) begin
          checks++; if (imemReq !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("FAIL rnd_wait%0d got req=%h v=%h want 0/0", n, imemReq, instrValid); end
          imemAck = ($urandom_range(0, 1) == 1);
          nextPCValid = (i == d);
          t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
          toPC = t;
          if (i == d) latest = t;
          step;
        end
        nextPCValid = 1'b0; imemAck = 1'b0;
      end
      expAddr = modelTarget(latest);
      expFault = expFault | modelFault(latest);
    end
  endtask

  initial begin
    test_reset;
    test_first_fetch;
    test_taken_with_pc;
    test_ack_delay;
    test_latest_wins;
    test_misaligned;
    test_pc_wrap;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
